edge_write_ctrl: RTL and testbench
==================================

Name: edge_write_ctrl

Overview:
- Downstream neighbour of the result buffer. Takes each 32-bit output word and its one-cycle write-enable pulse, and performs the write to frame memory.
- Memory interface is a simple request/ready bus. The block generates sequential word addresses from a base address and a pixel index.
- Returns a one-cycle write-complete pulse, which releases the buffer to present its next word. Tracks frame completion and flags bus faults.

Parameters:
ADDR_W, 16, width of memory address and base address
FRAME_PIXELS, 4096, output words per frame; pixel index wraps after FRAME_PIXELS-1
TIMEOUT, 255, max cycles to wait for i_mem_ready before abandoning a request

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  asynchronous active-low reset
i_write_enable  in  1  one-cycle pulse: i_buffer2_data valid, write requested
i_buffer2_data  in  32  word to store
i_base_addr  in  ADDR_W  frame base byte address, sampled per request
i_frame_start  in  1  clear pixel index to 0 (new frame)
i_mem_ready  in  1  memory accepts current request this cycle
o_mem_write  out  1  write request, held until accepted or timed out
o_mem_addr  out  ADDR_W  byte address of request
o_mem_wdata  out  32  data of request
o_write_complete  out  1  one-cycle pulse: current word finished
o_frame_done  out  1  one-cycle pulse coincident with completion of last word of frame
o_error  out  1  sticky: timeout or overrun occurred
o_pixel_index  out  $clog2(FRAME_PIXELS)  index of next word to write

Behaviour:
- Reset (n_rst=0, async): state IDLE. All outputs 0. Index 0, timeout counter 0.
- All outputs are registered.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On i_write_enable=1: latch o_mem_wdata=i_buffer2_data and o_mem_addr=i_base_addr+(index<<2) (modulo 2^ADDR_W).
  - Same edge: set o_mem_write=1, clear timeout counter, go to REQ.
- REQ:
  - o_mem_write, o_mem_addr and o_mem_wdata are held stable.
  - If i_mem_ready=1, the request is accepted: o_mem_write=0 at the next edge, go to DONE.
  - Else the counter increments. When the counter reaches TIMEOUT without ready: drop o_mem_write, set o_error, go to DONE. The word is discarded but the handshake still completes, so the upstream buffer never deadlocks.
- DONE (one cycle):
  - o_write_complete=1.
  - Index increments. At FRAME_PIXELS-1 it wraps to 0 and o_frame_done=1 in the same cycle.
  - Return to IDLE.
- Latency, write_enable sampled at edge N:
  - o_mem_write high from N+1.
  - Ready at N+1 gives o_write_complete at N+2.
  - Minimum 3 cycles per word, including the IDLE cycle.
- i_write_enable outside IDLE is ignored and sets o_error (overrun). The current transaction is unaffected.
- i_frame_start:
  - In IDLE: index cleared at the next edge.
  - In REQ/DONE: recorded as pending and applied on the DONE→IDLE transition, overriding the increment. o_frame_done is still produced if that word was the last one.
- i_frame_start and i_write_enable together in IDLE: clear applies first; the request uses index 0.
- o_error clears only on reset.
- Reset mid-REQ: request dropped immediately, no completion pulse.

Decomposition:
- Package edge_pkg holds:
  - wctrl_state_t enum {IDLE, REQ, DONE};
  - the BYTES_PER_WORD=4 constant;
  - the shared 32-bit word typedef used by the buffer and this block.
- Sub-module: pixel_addr_gen, containing the index counter with wrap, pending-clear and frame_done, plus the address adder. The FSM instantiates it once.

Test Plan:
- Reset, then i_write_enable with data 0xA5A5A5A5, base 0x1000, ready tied 1 -> o_mem_write at N+1 with addr 0x1000 and wdata 0xA5A5A5A5; o_write_complete at N+2; o_pixel_index=1.
- Three consecutive words, ready tied 1 -> addresses 0x1000, 0x1004, 0x1008; exactly 3 complete pulses.
- Ready delayed 5 cycles -> o_mem_write held for 6 cycles with addr/data stable; one complete pulse; o_error=0.
- Ready never asserted, TIMEOUT=255 -> o_mem_write drops after 255 cycles, o_error=1, complete pulse still issued, index advances.
- FRAME_PIXELS=9, 9 writes -> o_frame_done together with the 9th complete; index 0; next address equals base.
- i_frame_start pulsed during REQ of word 3 -> word 3 completes at base+8; next write goes to base+0. Extra i_write_enable during REQ -> o_error=1 and no extra write.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and constants for the frame-memory write path.
package edge_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } wctrl_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/edge_write_ctrl_pixel_addr_gen.sv
// Pixel index counter with frame wrap and deferred frame-start clear,
// plus the byte address adder used for each memory request.
module pixel_addr_gen
    import edge_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int FRAME_PIXELS = 4096,
    localparam int IDX_W       = $clog2(FRAME_PIXELS)
)(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_frame_start,
    input  logic              i_idle,
    input  logic              i_advance,
    input  logic              i_release,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic [IDX_W-1:0]  o_index,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [IDX_W-1:0] r_index;
    logic             r_clr_pend;
    logic             w_clr_now;
    logic [IDX_W-1:0] w_idx_eff;

    assign w_clr_now = i_frame_start && i_idle;
    assign o_last    = (r_index == IDX_W'(FRAME_PIXELS - 1));
    // A frame start seen together with a write request addresses pixel 0.
    assign w_idx_eff = w_clr_now ? '0 : r_index;
    assign o_addr    = i_base_addr + (ADDR_W'(w_idx_eff) << WORD_SHIFT);
    assign o_index   = r_index;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_index    <= '0;
            r_clr_pend <= 1'b0;
        end else begin
            if (w_clr_now) begin
                r_index <= '0;
            end else if (i_advance) begin
                r_index <= o_last ? '0 : r_index + IDX_W'(1);
            end else if (i_release && (r_clr_pend || i_frame_start)) begin
                r_index <= '0;
            end

            if (i_release) begin
                r_clr_pend <= 1'b0;
            end else if (i_frame_start && !i_idle) begin
                r_clr_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_write_ctrl.sv
// Write controller: turns buffer write pulses into request/ready memory
// writes, returns a completion pulse per word, and flags timeouts/overruns.
module edge_write_ctrl
    import edge_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int FRAME_PIXELS = 4096,
    parameter int TIMEOUT      = 255,
    localparam int IDX_W       = $clog2(FRAME_PIXELS)
)(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_write_enable,
    input  word_t             i_buffer2_data,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_frame_start,
    input  logic              i_mem_ready,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output word_t             o_mem_wdata,
    output logic              o_write_complete,
    output logic              o_frame_done,
    output logic              o_error,
    output logic [IDX_W-1:0]  o_pixel_index
);

    // state | meaning
    // IDLE  | waiting for a write pulse from the buffer
    // REQ   | request on the bus, waiting for ready or timeout
    // DONE  | one-cycle completion pulse, index already advanced

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    wctrl_state_t      r_state;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    word_t             r_mem_wdata;
    logic              r_write_complete;
    logic              r_frame_done;
    logic              r_error;
    logic [CNT_W-1:0]  r_cnt;

    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_timeout;
    logic              w_finish;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;

    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT));
    assign w_finish   = (r_state == REQ) && (i_mem_ready || w_timeout);

    pixel_addr_gen #(
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) u_addr_gen (
        .clk           (clk),
        .n_rst         (n_rst),
        .i_frame_start (i_frame_start),
        .i_idle        (r_state == IDLE),
        .i_advance     (w_finish),
        .i_release     (r_state == DONE),
        .i_base_addr   (i_base_addr),
        .o_index       (o_pixel_index),
        .o_addr        (w_addr),
        .o_last        (w_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state          <= IDLE;
            r_mem_write      <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_write_complete <= 1'b0;
            r_frame_done     <= 1'b0;
            r_error          <= 1'b0;
            r_cnt            <= '0;
        end else begin
            r_write_complete <= 1'b0;
            r_frame_done     <= 1'b0;
            if (i_write_enable && (r_state != IDLE)) begin
                r_error <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (i_write_enable) begin
                        r_mem_wdata <= i_buffer2_data;
                        r_mem_addr  <= w_addr;
                        r_mem_write <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    r_cnt <= w_cnt_next;
                    // Ready wins over a timeout landing on the same edge.
                    if (w_finish) begin
                        r_mem_write      <= 1'b0;
                        r_write_complete <= 1'b1;
                        r_frame_done     <= w_last;
                        r_state          <= DONE;
                        if (!i_mem_ready) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_write      = r_mem_write;
    assign o_mem_addr       = r_mem_addr;
    assign o_mem_wdata      = r_mem_wdata;
    assign o_write_complete = r_write_complete;
    assign o_frame_done     = r_frame_done;
    assign o_error          = r_error;

endmodule

// File: tb/tb_edge_write_ctrl.sv
// Directed bench for edge_write_ctrl with a 9-pixel frame and 255-cycle timeout.
module tb_edge_write_ctrl;

    localparam int ADDR_W       = 16;
    localparam int FRAME_PIXELS = 9;
    localparam int TIMEOUT      = 255;
    localparam int IDX_W        = $clog2(FRAME_PIXELS);

    logic              clk = 1'b0;
    logic              n_rst;
    logic              i_write_enable;
    logic [31:0]       i_buffer2_data;
    logic [ADDR_W-1:0] i_base_addr;
    logic              i_frame_start;
    logic              i_mem_ready;
    logic              o_mem_write;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              o_write_complete;
    logic              o_frame_done;
    logic              o_error;
    logic [IDX_W-1:0]  o_pixel_index;

    int n_checks = 0;
    int n_errors = 0;

    edge_write_ctrl #(
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FRAME_PIXELS),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_write_enable   (i_write_enable),
        .i_buffer2_data   (i_buffer2_data),
        .i_base_addr      (i_base_addr),
        .i_frame_start    (i_frame_start),
        .i_mem_ready      (i_mem_ready),
        .o_mem_write      (o_mem_write),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wdata      (o_mem_wdata),
        .o_write_complete (o_write_complete),
        .o_frame_done     (o_frame_done),
        .o_error          (o_error),
        .o_pixel_index    (o_pixel_index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One word with ready tied high: REQ cycle, DONE cycle, back to IDLE.
    task automatic write_word(input logic [31:0] data, input logic fs,
                              input logic [31:0] exp_addr, input logic exp_fd,
                              input logic [31:0] exp_idx);
        i_buffer2_data = data;
        i_frame_start  = fs;
        i_write_enable = 1'b1;
        tick();
        i_write_enable = 1'b0;
        i_frame_start  = 1'b0;
        chk("ww_req_write", {31'd0, o_mem_write}, 32'd1);
        chk("ww_req_addr", {16'd0, o_mem_addr}, exp_addr);
        chk("ww_req_data", o_mem_wdata, data);
        tick();
        chk("ww_complete", {31'd0, o_write_complete}, 32'd1);
        chk("ww_frame_done", {31'd0, o_frame_done}, {31'd0, exp_fd});
        chk("ww_index", {28'd0, o_pixel_index}, exp_idx);
        tick();
        chk("ww_idle_complete", {31'd0, o_write_complete}, 32'd0);
    endtask

    initial begin
        int pulses;
        int hi;

        n_rst          = 1'b0;
        i_write_enable = 1'b0;
        i_buffer2_data = '0;
        i_base_addr    = '0;
        i_frame_start  = 1'b0;
        i_mem_ready    = 1'b0;
        tick();
        tick();
        chk("rst_write", {31'd0, o_mem_write}, 32'd0);
        chk("rst_addr", {16'd0, o_mem_addr}, 32'd0);
        chk("rst_data", o_mem_wdata, 32'd0);
        chk("rst_complete", {31'd0, o_write_complete}, 32'd0);
        chk("rst_error", {31'd0, o_error}, 32'd0);
        chk("rst_index", {28'd0, o_pixel_index}, 32'd0);
        n_rst = 1'b1;
        tick();

        // First word: request visible one edge after the pulse, completion one later.
        i_base_addr    = 16'h1000;
        i_mem_ready    = 1'b1;
        i_buffer2_data = 32'hA5A5_A5A5;
        i_write_enable = 1'b1;
        tick();
        i_write_enable = 1'b0;
        chk("t1_write", {31'd0, o_mem_write}, 32'd1);
        chk("t1_addr", {16'd0, o_mem_addr}, 32'h1000);
        chk("t1_data", o_mem_wdata, 32'hA5A5_A5A5);
        chk("t1_no_complete_yet", {31'd0, o_write_complete}, 32'd0);
        tick();
        chk("t1_complete", {31'd0, o_write_complete}, 32'd1);
        chk("t1_write_dropped", {31'd0, o_mem_write}, 32'd0);
        chk("t1_index", {28'd0, o_pixel_index}, 32'd1);
        tick();
        chk("t1_complete_gone", {31'd0, o_write_complete}, 32'd0);

        // Three consecutive words from a fresh frame start.
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            i_buffer2_data = 32'h1111_0000 + k;
            i_frame_start  = (k == 0);
            i_write_enable = 1'b1;
            tick();
            i_write_enable = 1'b0;
            i_frame_start  = 1'b0;
            chk("t2_addr", {16'd0, o_mem_addr}, 32'h1000 + 4 * k);
            if (o_write_complete) pulses++;
            tick();
            if (o_write_complete) pulses++;
            tick();
            if (o_write_complete) pulses++;
        end
        chk("t2_pulses", pulses, 32'd3);
        chk("t2_index", {28'd0, o_pixel_index}, 32'd3);

        // Ready five cycles late: request held six cycles, stable.
        i_mem_ready    = 1'b0;
        i_buffer2_data = 32'hDEAD_BEEF;
        i_write_enable = 1'b1;
        tick();
        i_write_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_write", {31'd0, o_mem_write}, 32'd1);
            chk("t3_hold_addr", {16'd0, o_mem_addr}, 32'h100C);
            chk("t3_hold_data", o_mem_wdata, 32'hDEAD_BEEF);
            tick();
        end
        chk("t3_sixth_cycle", {31'd0, o_mem_write}, 32'd1);
        i_mem_ready = 1'b1;
        tick();
        chk("t3_complete", {31'd0, o_write_complete}, 32'd1);
        chk("t3_write_dropped", {31'd0, o_mem_write}, 32'd0);
        chk("t3_no_error", {31'd0, o_error}, 32'd0);
        tick();
        chk("t3_single_pulse", {31'd0, o_write_complete}, 32'd0);
        chk("t3_index", {28'd0, o_pixel_index}, 32'd4);

        // Full 9-pixel frame, then the next word lands on the base again.
        i_base_addr = 16'h2000;
        for (int k = 0; k < FRAME_PIXELS; k++) begin
            write_word(32'h2222_0000 + k, (k == 0), 32'h2000 + 4 * k,
                       (k == FRAME_PIXELS - 1), (k == FRAME_PIXELS - 1) ? 0 : k + 1);
        end
        write_word(32'h2222_FFFF, 1'b0, 32'h2000, 1'b0, 32'd1);
        chk("t5_no_error", {31'd0, o_error}, 32'd0);

        // Frame start and an overrun pulse during REQ of word 3.
        i_base_addr = 16'h4000;
        write_word(32'h4444_0000, 1'b1, 32'h4000, 1'b0, 32'd1);
        write_word(32'h4444_0001, 1'b0, 32'h4004, 1'b0, 32'd2);
        i_mem_ready    = 1'b0;
        i_buffer2_data = 32'h4444_0002;
        i_write_enable = 1'b1;
        tick();
        i_buffer2_data = 32'h9999_9999;
        i_frame_start  = 1'b1;
        tick();
        i_write_enable = 1'b0;
        i_frame_start  = 1'b0;
        chk("t6_overrun_error", {31'd0, o_error}, 32'd1);
        chk("t6_req_held", {31'd0, o_mem_write}, 32'd1);
        chk("t6_addr_held", {16'd0, o_mem_addr}, 32'h4008);
        chk("t6_data_held", o_mem_wdata, 32'h4444_0002);
        i_mem_ready = 1'b1;
        tick();
        chk("t6_complete", {31'd0, o_write_complete}, 32'd1);
        tick();
        chk("t6_index_cleared", {28'd0, o_pixel_index}, 32'd0);
        chk("t6_no_extra_write", {31'd0, o_mem_write}, 32'd0);
        tick();
        chk("t6_still_idle", {31'd0, o_mem_write}, 32'd0);
        write_word(32'h4444_0003, 1'b0, 32'h4000, 1'b0, 32'd1);

        // Reset in the middle of a request.
        i_mem_ready    = 1'b0;
        i_write_enable = 1'b1;
        tick();
        i_write_enable = 1'b0;
        chk("t7_req_up", {31'd0, o_mem_write}, 32'd1);
        n_rst = 1'b0;
        #1;
        chk("t7_write_dropped", {31'd0, o_mem_write}, 32'd0);
        chk("t7_no_complete", {31'd0, o_write_complete}, 32'd0);
        chk("t7_error_cleared", {31'd0, o_error}, 32'd0);
        chk("t7_index_cleared", {28'd0, o_pixel_index}, 32'd0);
        tick();
        n_rst = 1'b1;
        tick();
        chk("t7_idle_after", {31'd0, o_write_complete}, 32'd0);

        // Ready never comes: request abandoned after TIMEOUT cycles.
        i_base_addr    = 16'h3000;
        i_buffer2_data = 32'h3333_3333;
        i_write_enable = 1'b1;
        tick();
        i_write_enable = 1'b0;
        chk("t4_addr", {16'd0, o_mem_addr}, 32'h3000);
        hi = 0;
        while (o_mem_write && hi < 300) begin
            hi++;
            tick();
        end
        chk("t4_high_cycles", hi, TIMEOUT);
        chk("t4_complete", {31'd0, o_write_complete}, 32'd1);
        chk("t4_error", {31'd0, o_error}, 32'd1);
        chk("t4_index", {28'd0, o_pixel_index}, 32'd1);
        tick();
        chk("t4_complete_gone", {31'd0, o_write_complete}, 32'd0);
        chk("t4_error_sticky", {31'd0, o_error}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
